// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
// Time-multiplexed driver for N_DIGITS common-select 7-segment digits.
// A prescaler divides each digit slot into SCAN_DIV cycles. The first
// BLANK_CYCLES of every slot keep all selects off to avoid ghosting. Digit
// values are snapshotted once per frame so a frame is always coherent.
// All outputs are registered.
//
// Optional build macro:
//   SEVEN_SEGMENT_SCANNER_LZ_BLANK_EN - leading-zero suppression; digit i > 0
//   shows no segments while nibbles i..N_DIGITS-1 are all zero.

module seven_segment_scanner #(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dots,
    output logic [6:0]            abcdefg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   digit_sel,
    output logic                  frame_start
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

    // ST_LOAD is the post-reset state: the snapshot is still pending and
    // is taken on the first enabled edge.
    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [PW-1:0]         pcnt;
    logic [IW-1:0]         idx;
    logic [4*N_DIGITS-1:0] snap_digits;
    logic [N_DIGITS-1:0]   snap_dots;

    logic scanning;
    logic pcnt_wrap;
    logic idx_wrap;
    logic snap_load;
    logic in_blank;

    logic [3:0] cur_nib;
    logic       cur_dot;
    logic       lz_hit;

    logic [6:0]          seg_nxt;
    logic                dp_nxt;
    logic [N_DIGITS-1:0] sel_nxt;
    logic                fs_nxt;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // Scan control derived from the counters and the enable
    always_comb begin
        scanning  = en && (state == ST_SCAN);
        pcnt_wrap = (pcnt == PCNT_LAST);
        idx_wrap  = (idx == IDX_LAST);
        snap_load = en && ((state == ST_LOAD) ||
                           ((state == ST_SCAN) && pcnt_wrap && idx_wrap));
    end

    // Anti-ghosting window at the start of each slot
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (pcnt < PW'(BLANK_CYCLES));
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: leave LOAD on the first enabled edge, then scan forever
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: if (en) state_nxt = ST_SCAN;
            ST_SCAN: state_nxt = ST_SCAN;
            default: state_nxt = ST_LOAD;
        endcase
    end

    // Prescaler and digit index; both hold while disabled or loading
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (scanning) begin
            if (pcnt_wrap) begin
                pcnt <= '0;
                idx  <= idx_wrap ? '0 : idx + 1'b1;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

    // Frame-coherent snapshot of the digit values and dots
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_digits <= '0;
            snap_dots   <= '0;
        end else if (snap_load) begin
            snap_digits <= digits;
            snap_dots   <= dots;
        end
    end

`ifdef SEVEN_SEGMENT_SCANNER_LZ_BLANK_EN
    logic [N_DIGITS-1:0] zero_from;
    logic                zero_run;

    // zero_from[i] is set when snapshot nibbles i..N_DIGITS-1 are all zero
    always_comb begin
        zero_from = '0;
        zero_run  = 1'b1;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            zero_run = zero_run &&
                       (snap_digits[4*(N_DIGITS-1-k) +: 4] == 4'h0);
            zero_from[N_DIGITS-1-k] = zero_run;
        end
    end

    // Active nibble/dot mux, plus leading-zero test for digits above 0
    always_comb begin
        cur_nib = '0;
        cur_dot = 1'b0;
        lz_hit  = 1'b0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib = snap_digits[4*i +: 4];
                cur_dot = snap_dots[i];
                lz_hit  = (i != 0) && zero_from[i];
            end
        end
    end
`else
    // Active nibble/dot mux
    always_comb begin
        cur_nib = '0;
        cur_dot = 1'b0;
        lz_hit  = 1'b0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib = snap_digits[4*i +: 4];
                cur_dot = snap_dots[i];
            end
        end
    end
`endif

    // FSM outputs: next pin values from the current counter state
    always_comb begin
        seg_nxt = '0;
        dp_nxt  = 1'b0;
        sel_nxt = '0;
        fs_nxt  = 1'b0;
        if (scanning) begin
            fs_nxt = (pcnt == '0) && (idx == '0);
            if (!in_blank) begin
                for (int unsigned i = 0; i < N_DIGITS; i++) begin
                    sel_nxt[i] = (idx == IW'(i));
                end
                seg_nxt = lz_hit ? 7'b0000000 : seg_decode(cur_nib);
                dp_nxt  = cur_dot;
            end
        end
    end

    // Output registers, one cycle behind the counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abcdefg     <= '0;
            dp          <= 1'b0;
            digit_sel   <= '0;
            frame_start <= 1'b0;
        end else begin
            abcdefg     <= seg_nxt;
            dp          <= dp_nxt;
            digit_sel   <= sel_nxt;
            frame_start <= fs_nxt;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Testbench for seven_segment_scanner (N_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1).
// Table-driven per-cycle vectors plus hand-written reset and decode sequences.

module tb_seven_segment_scanner;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dots;
    logic [6:0]  abcdefg;
    logic        dp;
    logic [3:0]  digit_sel;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

`ifdef SEVEN_SEGMENT_SCANNER_LZ_BLANK_EN
    localparam logic [6:0] ZG = 7'b0000000;
`else
    localparam logic [6:0] ZG = 7'b1111110;
`endif

    localparam logic [6:0] G0 = 7'b1111110;
    localparam logic [6:0] G1 = 7'b0110000;
    localparam logic [6:0] G2 = 7'b1101101;
    localparam logic [6:0] G5 = 7'b1011011;
    localparam logic [6:0] GA = 7'b1110111;
    localparam logic [6:0] GF = 7'b1000111;

    typedef struct {
        int          n;
        logic        en;
        logic [15:0] digits;
        logic [3:0]  dots;
        logic [3:0]  sel;
        logic [6:0]  seg;
        logic        dp;
        logic        fs;
    } vec_t;

    vec_t vecs[$];

    seven_segment_scanner #(
        .N_DIGITS(4),
        .SCAN_DIV(4),
        .BLANK_CYCLES(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .digits(digits),
        .dots(dots),
        .abcdefg(abcdefg),
        .dp(dp),
        .digit_sel(digit_sel),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0:  return 7'b1111110;
            1:  return 7'b0110000;
            2:  return 7'b1101101;
            3:  return 7'b1111001;
            4:  return 7'b0110011;
            5:  return 7'b1011011;
            6:  return 7'b1011111;
            7:  return 7'b1110000;
            8:  return 7'b1111111;
            9:  return 7'b1111011;
            10: return 7'b1110111;
            11: return 7'b0011111;
            12: return 7'b1001110;
            13: return 7'b0111101;
            14: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] sel, input logic [6:0] seg,
                              input logic dpe, input logic fs);
        check({tag, ".sel"}, 32'(digit_sel), 32'(sel));
        check({tag, ".seg"}, 32'(abcdefg), 32'(seg));
        check({tag, ".dp"}, 32'(dp), 32'(dpe));
        check({tag, ".fs"}, 32'(frame_start), 32'(fs));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input int n, input logic e, input logic [15:0] d, input logic [3:0] dt,
                       input logic [3:0] sel, input logic [6:0] seg, input logic dpe, input logic fs);
        vec_t v;
        v.n = n; v.en = e; v.digits = d; v.dots = dt;
        v.sel = sel; v.seg = seg; v.dp = dpe; v.fs = fs;
        vecs.push_back(v);
    endtask

    initial begin
        // Each row: cycles, en, digits, dots, expected sel/seg/dp/frame_start
        add(1,  1'b1, 16'h12AF, 4'b0001, 4'b0000, 7'b0, 1'b0, 1'b0); // snapshot load edge
        add(1,  1'b1, 16'h12AF, 4'b0001, 4'b0000, 7'b0, 1'b0, 1'b1); // slot 0 blank
        add(3,  1'b1, 16'h12AF, 4'b0001, 4'b0001, GF,   1'b1, 1'b0);
        add(1,  1'b1, 16'h12AF, 4'b0001, 4'b0000, 7'b0, 1'b0, 1'b0);
        add(3,  1'b1, 16'h12AF, 4'b0001, 4'b0010, GA,   1'b0, 1'b0);
        add(1,  1'b1, 16'h12AF, 4'b0001, 4'b0000, 7'b0, 1'b0, 1'b0);
        add(1,  1'b1, 16'h0000, 4'b0001, 4'b0100, G2,   1'b0, 1'b0); // input changes mid-frame
        add(2,  1'b1, 16'h0000, 4'b0001, 4'b0100, G2,   1'b0, 1'b0);
        add(1,  1'b1, 16'h0000, 4'b0001, 4'b0000, 7'b0, 1'b0, 1'b0);
        add(3,  1'b1, 16'h0000, 4'b0001, 4'b1000, G1,   1'b0, 1'b0);
        add(1,  1'b1, 16'h0000, 4'b0001, 4'b0000, 7'b0, 1'b0, 1'b1); // frame 2: all zero
        add(3,  1'b1, 16'h0000, 4'b0001, 4'b0001, G0,   1'b1, 1'b0);
        add(1,  1'b1, 16'h0000, 4'b0001, 4'b0000, 7'b0, 1'b0, 1'b0);
        add(3,  1'b1, 16'h0050, 4'b0001, 4'b0010, ZG,   1'b0, 1'b0);
        add(1,  1'b1, 16'h0050, 4'b0001, 4'b0000, 7'b0, 1'b0, 1'b0);
        add(3,  1'b1, 16'h0050, 4'b0001, 4'b0100, ZG,   1'b0, 1'b0);
        add(1,  1'b1, 16'h0050, 4'b0001, 4'b0000, 7'b0, 1'b0, 1'b0);
        add(3,  1'b1, 16'h0050, 4'b0001, 4'b1000, ZG,   1'b0, 1'b0);
        add(1,  1'b1, 16'h0050, 4'b0001, 4'b0000, 7'b0, 1'b0, 1'b1); // frame 3: 0050
        add(3,  1'b1, 16'h0050, 4'b0001, 4'b0001, G0,   1'b1, 1'b0);
        add(1,  1'b1, 16'h0050, 4'b0001, 4'b0000, 7'b0, 1'b0, 1'b0);
        add(3,  1'b1, 16'h0050, 4'b0001, 4'b0010, G5,   1'b0, 1'b0);
        add(1,  1'b1, 16'h0050, 4'b0001, 4'b0000, 7'b0, 1'b0, 1'b0);
        add(3,  1'b1, 16'h0050, 4'b0001, 4'b0100, ZG,   1'b0, 1'b0);
        add(1,  1'b1, 16'h0050, 4'b0001, 4'b0000, 7'b0, 1'b0, 1'b0);
        add(3,  1'b1, 16'h0050, 4'b0001, 4'b1000, ZG,   1'b0, 1'b0);
        add(1,  1'b1, 16'h0050, 4'b0001, 4'b0000, 7'b0, 1'b0, 1'b1); // frame 4
        add(3,  1'b1, 16'h0050, 4'b0001, 4'b0001, G0,   1'b1, 1'b0);
        add(1,  1'b1, 16'h0050, 4'b0001, 4'b0000, 7'b0, 1'b0, 1'b0);
        add(1,  1'b1, 16'h0050, 4'b0001, 4'b0010, G5,   1'b0, 1'b0); // digit 1, first lit cycle
        add(10, 1'b0, 16'h0050, 4'b0001, 4'b0000, 7'b0, 1'b0, 1'b0); // en low: frozen, dark
        add(2,  1'b1, 16'h0050, 4'b0001, 4'b0010, G5,   1'b0, 1'b0); // digit 1 remainder
        add(1,  1'b1, 16'h0050, 4'b0001, 4'b0000, 7'b0, 1'b0, 1'b0);
        add(2,  1'b1, 16'h0050, 4'b0001, 4'b0100, ZG,   1'b0, 1'b0); // mid-slot of digit 2

        rst_n  = 1'b0;
        en     = 1'b0;
        digits = '0;
        dots   = '0;
        repeat (3) @(negedge clk);
        check_outs("reset", 4'b0000, 7'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_outs("idle_en0", 4'b0000, 7'b0, 1'b0, 1'b0);

        foreach (vecs[r]) begin
            for (int c = 0; c < vecs[r].n; c++) begin
                en     = vecs[r].en;
                digits = vecs[r].digits;
                dots   = vecs[r].dots;
                tick();
                check_outs($sformatf("row%0d.c%0d", r, c),
                           vecs[r].sel, vecs[r].seg, vecs[r].dp, vecs[r].fs);
            end
        end

        // Asynchronous reset in the middle of digit 2's slot
        #2 rst_n = 1'b0;
        #1 check_outs("async_rst", 4'b0000, 7'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("in_rst", 4'b0000, 7'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_outs("rst_load", 4'b0000, 7'b0, 1'b0, 1'b0);
        tick();
        check_outs("rst_s0_blank", 4'b0000, 7'b0, 1'b0, 1'b1);
        tick();
        check_outs("rst_s0_lit", 4'b0001, G0, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        check_outs("rst_s1_blank", 4'b0000, 7'b0, 1'b0, 1'b0);
        tick();
        check_outs("rst_s1_lit", 4'b0010, G5, 1'b0, 1'b0);

        // Decode sweep of digit 0 over all hex values
        for (int v = 0; v < 16; v++) begin
            int w;
            logic [3:0] nib;
            nib    = 4'(v);
            digits = {12'h000, nib};
            w = 0;
            while (frame_start !== 1'b1 && w < 40) begin
                tick();
                w++;
            end
            check($sformatf("sweep%0d.fs_seen", v), 32'(frame_start), 32'd1);
            tick();
            check($sformatf("sweep%0d.sel", v), 32'(digit_sel), 32'b0001);
            check($sformatf("sweep%0d.seg", v), 32'(abcdefg), 32'(glyph(v)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
